// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the FSM encodings, the bubble encoding and the fetch-buffer entry layout.
package if_stage_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  typedef enum logic [1:0] {
    IF_RUN      = 2'd0,
    IF_DRAIN    = 2'd1,
    IF_BUFFERED = 2'd2
  } if_state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc4;
    logic        full;
  } fb_entry_t;

  // Fetch addresses are word aligned; low two bits of any target are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and memory.
interface if_stage_if;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        imem_ready;

  modport master (output imem_addr, imem_req, input imem_rdata, imem_ready);
  modport slave  (input imem_addr, imem_req, output imem_rdata, imem_ready);
endinterface

// File: rtl/if_stage_fetch_buffer.sv
// One-entry holding register for a word fetched while decode is stalled.
// drain only empties the entry; clear also wipes the stored data.
module if_stage_fetch_buffer
  import if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        load,
  input  logic        drain,
  input  logic        clear,
  input  logic [31:0] inst_in,
  input  logic [31:0] pc4_in,
  output fb_entry_t   entry
);

  fb_entry_t entry_q, entry_d;

  always_comb begin
    entry_d = entry_q;
    if (clear) begin
      entry_d = '0;
    end else if (load) begin
      entry_d.inst = inst_in;
      entry_d.pc4  = pc4_in;
      entry_d.full = 1'b1;
    end else if (drain) begin
      entry_d.full = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) entry_q <= '0;
    else         entry_q <= entry_d;
  end

  assign entry = entry_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC select, imem handshake and IF/ID register.
//   state       | meaning
//   IF_RUN      | fetching at PC, request outstanding
//   IF_DRAIN    | redirect pending, waiting for the in-flight fetch to finish
//   IF_BUFFERED | decode stalled, next word parked in the fetch buffer
module if_stage
  import if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        stall,
  input  logic        branch,
  input  logic        jump,
  input  logic        jr,
  input  logic [31:0] bpc,
  input  logic [31:0] jpc,
  input  logic [31:0] rpc,
  if_stage_if.master  imem,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc4,
  output logic        id_valid
);

  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic [31:0] id_pc4_q, id_pc4_d;
  logic        id_valid_q, id_valid_d;

  logic        redirect;
  logic        ready;
  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic        fb_load, fb_drain, fb_clear;
  fb_entry_t   fb;

  // A branch seen during a stall has stale operands, so it is ignored.
  assign redirect = branch & ~stall;
  assign ready    = imem.imem_ready;
  assign target   = align_pc(jr ? rpc : (jump ? jpc : bpc));
  assign pc_plus4 = pc_q + 32'd4;

  if_stage_fetch_buffer u_fetch_buffer (
    .clk     (clk),
    .resetn  (resetn),
    .load    (fb_load),
    .drain   (fb_drain),
    .clear   (fb_clear),
    .inst_in (imem.imem_rdata),
    .pc4_in  (pc_plus4),
    .entry   (fb)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IF_RUN;
      pc_q       <= RESET_PC;
      redir_pc_q <= '0;
      id_inst_q  <= NOP_INST;
      id_pc4_q   <= '0;
      id_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      redir_pc_q <= redir_pc_d;
      id_inst_q  <= id_inst_d;
      id_pc4_q   <= id_pc4_d;
      id_valid_q <= id_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IF_RUN: begin
        if (redirect) begin
          if (!ready) state_d = IF_DRAIN;
        end else if (stall && ready) begin
          state_d = IF_BUFFERED;
        end
      end
      IF_DRAIN:    if (ready) state_d = IF_RUN;
      IF_BUFFERED: if (!stall) state_d = IF_RUN;
      default:     state_d = IF_RUN;
    endcase
  end

  always_comb begin
    pc_d       = pc_q;
    redir_pc_d = redir_pc_q;
    id_inst_d  = id_inst_q;
    id_pc4_d   = id_pc4_q;
    id_valid_d = id_valid_q;
    fb_load    = 1'b0;
    fb_drain   = 1'b0;
    fb_clear   = 1'b0;
    case (state_q)
      IF_RUN: begin
        if (redirect) begin
          {id_inst_d, id_pc4_d, id_valid_d} = {NOP_INST, 32'd0, 1'b0};
          if (ready) pc_d = target;
          else       redir_pc_d = target;
        end else if (stall) begin
          if (ready) begin
            fb_load = 1'b1;
            pc_d    = pc_plus4;
          end
        end else if (ready) begin
          {id_inst_d, id_pc4_d, id_valid_d} = {imem.imem_rdata, pc_plus4, 1'b1};
          pc_d = pc_plus4;
        end else begin
          {id_inst_d, id_pc4_d, id_valid_d} = {NOP_INST, 32'd0, 1'b0};
        end
      end
      IF_DRAIN: begin
        {id_inst_d, id_pc4_d, id_valid_d} = {NOP_INST, 32'd0, 1'b0};
        if (redirect) redir_pc_d = target;
        // A redirect arriving on the completing cycle is the newest target.
        if (ready) pc_d = redirect ? target : redir_pc_q;
      end
      IF_BUFFERED: begin
        if (redirect) begin
          fb_clear = 1'b1;
          pc_d     = target;
          {id_inst_d, id_pc4_d, id_valid_d} = {NOP_INST, 32'd0, 1'b0};
        end else if (!stall) begin
          fb_drain = 1'b1;
          {id_inst_d, id_pc4_d, id_valid_d} = {fb.inst, fb.pc4, fb.full};
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    imem.imem_addr = pc_q;
    imem.imem_req  = resetn & (state_q != IF_BUFFERED);
    id_inst        = id_inst_q;
    id_pc4         = id_pc4_q;
    id_valid       = id_valid_q;
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed, table-driven bench for if_stage with a combinational instruction memory model.
module tb_if_stage;
  import if_stage_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        stall = 1'b0, branch = 1'b0, jump = 1'b0, jr = 1'b0;
  logic [31:0] bpc = '0, jpc = '0, rpc = '0;
  logic        ready_r = 1'b0;
  logic [31:0] id_inst, id_pc4;
  logic        id_valid;
  int          total = 0;
  int          bad = 0;

  if_stage_if mif();

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h2008_0001 + a;
  endfunction

  assign mif.imem_rdata = mem_word(mif.imem_addr);
  assign mif.imem_ready = ready_r;

  always #5 clk = ~clk;

  if_stage dut (
    .clk      (clk),
    .resetn   (resetn),
    .stall    (stall),
    .branch   (branch),
    .jump     (jump),
    .jr       (jr),
    .bpc      (bpc),
    .jpc      (jpc),
    .rpc      (rpc),
    .imem     (mif.master),
    .id_inst  (id_inst),
    .id_pc4   (id_pc4),
    .id_valid (id_valid)
  );

  typedef struct {
    logic        stall, branch, jump, jr, ready;
    logic [31:0] bpc, jpc, rpc;
    logic [31:0] e_addr;
    logic        e_req;
    logic [31:0] e_inst;
    logic [31:0] e_pc4;
    logic        e_valid;
  } vec_t;

  localparam int NV = 30;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic s, b, j, r, rdy,
                              input logic [31:0] bp, jp, rp, ea,
                              input logic er,
                              input logic [31:0] ei, ep,
                              input logic ev);
    vec_t v;
    v.stall = s; v.branch = b; v.jump = j; v.jr = r; v.ready = rdy;
    v.bpc = bp; v.jpc = jp; v.rpc = rp;
    v.e_addr = ea; v.e_req = er; v.e_inst = ei; v.e_pc4 = ep; v.e_valid = ev;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] ea, input logic er,
                         input logic [31:0] ei, input logic [31:0] ep, input logic ev);
    chk({tag, "_addr"}, mif.imem_addr, ea);
    chk({tag, "_req"}, {31'd0, mif.imem_req}, {31'd0, er});
    chk({tag, "_inst"}, id_inst, ei);
    chk({tag, "_valid"}, {31'd0, id_valid}, {31'd0, ev});
    if (ev) chk({tag, "_pc4"}, id_pc4, ep);
  endtask

  initial begin
    //              s  b  j  r rdy bpc           jpc           rpc           addr          req inst          pc4           v
    vecs[0]  = mk(0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0,        32'h4,        1, 32'h20080001, 32'h4,        1);
    vecs[1]  = mk(0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0,        32'h8,        1, 32'h20080005, 32'h8,        1);
    vecs[2]  = mk(0, 1, 0, 0, 1, 32'h40,       32'h0,        32'h0,        32'h40,       1, NOP_INST,     32'h0,        0);
    vecs[3]  = mk(0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0,        32'h44,       1, 32'h20080041, 32'h44,       1);
    vecs[4]  = mk(0, 1, 1, 1, 1, 32'h700,      32'h200,      32'h123,      32'h120,      1, NOP_INST,     32'h0,        0);
    vecs[5]  = mk(0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0,        32'h124,      1, 32'h20080121, 32'h124,      1);
    vecs[6]  = mk(0, 1, 1, 0, 1, 32'h500,      32'h300,      32'h0,        32'h300,      1, NOP_INST,     32'h0,        0);
    vecs[7]  = mk(0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h300,      1, NOP_INST,     32'h0,        0);
    vecs[8]  = mk(0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0,        32'h304,      1, 32'h20080301, 32'h304,      1);
    vecs[9]  = mk(1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h304,      1, 32'h20080301, 32'h304,      1);
    vecs[10] = mk(1, 1, 0, 0, 1, 32'h700,      32'h0,        32'h0,        32'h308,      0, 32'h20080301, 32'h304,      1);
    vecs[11] = mk(1, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0,        32'h308,      0, 32'h20080301, 32'h304,      1);
    vecs[12] = mk(1, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0,        32'h308,      0, 32'h20080301, 32'h304,      1);
    vecs[13] = mk(0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0,        32'h308,      1, 32'h20080305, 32'h308,      1);
    vecs[14] = mk(0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0,        32'h30C,      1, 32'h20080309, 32'h30C,      1);
    vecs[15] = mk(1, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0,        32'h310,      0, 32'h20080309, 32'h30C,      1);
    vecs[16] = mk(0, 1, 0, 0, 1, 32'h600,      32'h0,        32'h0,        32'h600,      1, NOP_INST,     32'h0,        0);
    vecs[17] = mk(0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0,        32'h604,      1, 32'h20080601, 32'h604,      1);
    vecs[18] = mk(0, 1, 0, 0, 0, 32'h80,       32'h0,        32'h0,        32'h604,      1, NOP_INST,     32'h0,        0);
    vecs[19] = mk(0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h604,      1, NOP_INST,     32'h0,        0);
    vecs[20] = mk(1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h604,      1, NOP_INST,     32'h0,        0);
    vecs[21] = mk(0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0,        32'h80,       1, NOP_INST,     32'h0,        0);
    vecs[22] = mk(0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0,        32'h84,       1, 32'h20080081, 32'h84,       1);
    vecs[23] = mk(0, 1, 0, 0, 0, 32'h90,       32'h0,        32'h0,        32'h84,       1, NOP_INST,     32'h0,        0);
    vecs[24] = mk(0, 1, 0, 0, 0, 32'hA0,       32'h0,        32'h0,        32'h84,       1, NOP_INST,     32'h0,        0);
    vecs[25] = mk(0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0,        32'hA0,       1, NOP_INST,     32'h0,        0);
    vecs[26] = mk(0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0,        32'hA4,       1, 32'h200800A1, 32'hA4,       1);
    vecs[27] = mk(0, 1, 0, 0, 1, 32'hFFFFFFFE, 32'h0,        32'h0,        32'hFFFFFFFC, 1, NOP_INST,     32'h0,        0);
    vecs[28] = mk(0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0,        32'h0,        1, 32'h2007FFFD, 32'h0,        1);
    vecs[29] = mk(0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0,        32'h4,        1, 32'h20080001, 32'h4,        1);

    // Held in reset across an edge.
    #12;
    chk_all("reset", RESET_PC, 1'b0, NOP_INST, 32'h0, 1'b0);
    chk("reset_pc4", id_pc4, 32'h0);
    #1 resetn = 1'b1;
    #1 chk("req_after_release", {31'd0, mif.imem_req}, 32'd1);

    for (int i = 0; i < NV; i++) begin
      stall = vecs[i].stall; branch = vecs[i].branch;
      jump = vecs[i].jump;   jr = vecs[i].jr;
      bpc = vecs[i].bpc;     jpc = vecs[i].jpc; rpc = vecs[i].rpc;
      ready_r = vecs[i].ready;
      @(posedge clk); #1;
      chk_all($sformatf("v%0d", i), vecs[i].e_addr, vecs[i].e_req,
              vecs[i].e_inst, vecs[i].e_pc4, vecs[i].e_valid);
    end

    // Asynchronous reset while draining a redirect.
    stall = 0; branch = 1; jump = 0; jr = 0; bpc = 32'h80; ready_r = 0;
    @(posedge clk); #1;
    chk_all("drain_enter", 32'h4, 1'b1, NOP_INST, 32'h0, 1'b0);
    branch = 0;
    #2 resetn = 1'b0;
    #1 chk_all("drain_rst", RESET_PC, 1'b0, NOP_INST, 32'h0, 1'b0);
    resetn = 1'b1; ready_r = 1;
    @(posedge clk); #1;
    chk_all("drain_rst_fetch", 32'h4, 1'b1, 32'h20080001, 32'h4, 1'b1);

    // Asynchronous reset while holding a buffered word.
    stall = 1;
    @(posedge clk); #1;
    chk_all("buf_enter", 32'h8, 1'b0, 32'h20080001, 32'h4, 1'b1);
    #2 resetn = 1'b0;
    #1 chk_all("buf_rst", RESET_PC, 1'b0, NOP_INST, 32'h0, 1'b0);
    resetn = 1'b1; stall = 0;
    #1 chk("buf_rst_req", {31'd0, mif.imem_req}, 32'd1);
    @(posedge clk); #1;
    chk_all("buf_rst_fetch", 32'h4, 1'b1, 32'h20080001, 32'h4, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
